// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run controller: FSM states, program-select
// encodings and default entry addresses.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ProgSel0       = 2'd0,
        ProgSel1       = 2'd1,
        ProgSel2       = 2'd2,
        ProgSelInvalid = 2'd3
    } prog_sel_e;

    localparam int unsigned DefAddrWidth  = 10;
    localparam int unsigned DefCountWidth = 16;
    localparam int unsigned DefP0Base     = 0;
    localparam int unsigned DefP1Base     = 256;
    localparam int unsigned DefP2Base     = 512;
    localparam int unsigned DefWdogLimit  = 'hFFFF;

    function automatic logic sel_valid(input logic [1:0] sel);
        return sel != ProgSelInvalid;
    endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Handshake and PC-control bundle between the requester/decoder side (master)
// and the run controller (slave).
interface run_ctrl_if #(
    parameter int unsigned A = 10,
    parameter int unsigned C = 16
);
    logic         Req;
    logic [1:0]   ProgSel;
    logic         Halt;
    logic         StallReq;
    logic         PcLoad;
    logic [A-1:0] PcLoadAddr;
    logic         PcEn;
    logic         Busy;
    logic         Done;
    logic         Err;
    logic         TimeOut;
    logic [C-1:0] CycleCount;

    modport master (
        output Req, ProgSel, Halt, StallReq,
        input  PcLoad, PcLoadAddr, PcEn, Busy, Done, Err, TimeOut, CycleCount
    );

    modport slave (
        input  Req, ProgSel, Halt, StallReq,
        output PcLoad, PcLoadAddr, PcEn, Busy, Done, Err, TimeOut, CycleCount
    );
endinterface

// File: rtl/run_ctrl_sat_counter.sv
// Width-parameterised up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);
    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {Width{1'b1}})) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: selects a program entry point, loads the PC, then gates PC advance
// until halt. Optional watchdog compiled in with RUN_CTRL_WATCHDOG_EN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned A          = DefAddrWidth,
    parameter int unsigned C          = DefCountWidth,
    parameter int unsigned P0_BASE    = DefP0Base,
    parameter int unsigned P1_BASE    = DefP1Base,
    parameter int unsigned P2_BASE    = DefP2Base,
    parameter int unsigned WDOG_LIMIT = DefWdogLimit
) (
    input logic     Clk,
    input logic     Reset,
    run_ctrl_if.slave bus
);
`ifdef RUN_CTRL_WATCHDOG_EN
    localparam bit WdogEn = 1'b1;
`else
    localparam bit WdogEn = 1'b0;
`endif
    localparam logic [C:0] WdogLimit = (C+1)'(WDOG_LIMIT);

    state_e       state_q, state_d;
    logic [1:0]   sel_q, sel_d;
    logic         err_q, err_d;
    logic         timeout_q, timeout_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         pc_load_q, pc_load_d;
    logic [A-1:0] pc_load_addr_q, pc_load_addr_d;
    logic [A-1:0] base_addr;
    logic [C-1:0] cycle_count;
    logic [C:0]   cycle_count_inc;
    logic         start, in_run, wdog_fire, pc_en;

    assign start           = (state_q == StIdle) && bus.Req;
    assign in_run          = (state_q == StRun);
    assign cycle_count_inc = {1'b0, cycle_count} + (C+1)'(1);
    // Fires on the RUN cycle that brings the count to the limit; halt wins.
    assign wdog_fire       = WdogEn && in_run && !bus.Halt && (cycle_count_inc >= WdogLimit);

    sat_counter #(
        .Width (C)
    ) u_cycle_cnt (
        .Clk     (Clk),
        .Reset   (Reset),
        .clr_i   (start),
        .en_i    (in_run),
        .count_o (cycle_count)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.Req) state_d = sel_valid(bus.ProgSel) ? StLoad : StDone;
            StLoad: state_d = StRun;
            StRun:  if (bus.Halt || wdog_fire) state_d = StDone;
            StDone: if (!bus.Req) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        base_addr = '0;
        unique case (prog_sel_e'(sel_d))
            ProgSel0: base_addr = A'(P0_BASE);
            ProgSel1: base_addr = A'(P1_BASE);
            ProgSel2: base_addr = A'(P2_BASE);
            default:  base_addr = '0;
        endcase
    end

    always_comb begin
        pc_en          = in_run && !bus.StallReq && !bus.Halt && !wdog_fire;
        sel_d          = (start && sel_valid(bus.ProgSel)) ? bus.ProgSel : sel_q;
        err_d          = start ? !sel_valid(bus.ProgSel) : err_q;
        timeout_d      = start ? 1'b0 : (timeout_q || wdog_fire);
        busy_d         = (state_d == StLoad) || (state_d == StRun);
        done_d         = (state_d == StDone);
        pc_load_d      = (state_d == StLoad);
        pc_load_addr_d = pc_load_d ? base_addr : '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel_q          <= 2'd0;
            err_q          <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pc_load_q      <= 1'b0;
            pc_load_addr_q <= '0;
        end else begin
            sel_q          <= sel_d;
            err_q          <= err_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pc_load_q      <= pc_load_d;
            pc_load_addr_q <= pc_load_addr_d;
        end
    end

    assign bus.PcEn       = pc_en;
    assign bus.PcLoad     = pc_load_q;
    assign bus.PcLoadAddr = pc_load_addr_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.Err        = err_q;
    assign bus.TimeOut    = timeout_q;
    assign bus.CycleCount = cycle_count;

endmodule
